// File: rtl/ef_spi_pkg.sv
// rtl/ef_spi_pkg.sv - register map, bit indices and shared types for ef_spi_apb
package ef_spi_pkg;

  localparam logic [15:0] ADDR_RXDATA = 16'h0000;
  localparam logic [15:0] ADDR_TXDATA = 16'h0004;
  localparam logic [15:0] ADDR_CFG    = 16'h0008;
  localparam logic [15:0] ADDR_CTRL   = 16'h000C;
  localparam logic [15:0] ADDR_PR     = 16'h0010;
  localparam logic [15:0] ADDR_STATUS = 16'h0014;
  localparam logic [15:0] ADDR_IM     = 16'hFF00;
  localparam logic [15:0] ADDR_MIS    = 16'hFF04;
  localparam logic [15:0] ADDR_RIS    = 16'hFF08;
  localparam logic [15:0] ADDR_IC     = 16'hFF0C;

  localparam int CFG_CPOL    = 0;
  localparam int CFG_CPHA    = 1;
  localparam int CTRL_SS     = 0;
  localparam int CTRL_EN     = 1;
  localparam int CTRL_LOOP   = 2;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_RXV  = 1;
  localparam int RIS_DONE    = 0;
  localparam int RIS_RXOV    = 1;

  localparam int PR_RESET = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } xfer_state_e;

endpackage

// File: rtl/ef_spi_master.sv
// rtl/ef_spi_master.sv - SCK prescaler, edge counter and shift registers
// for one DW-bit full-duplex transfer in any CPOL/CPHA mode.
module ef_spi_master
  import ef_spi_pkg::*;
#(
  parameter int PR_W = 8,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpol,
  input  logic            cpha,
  input  logic [PR_W-1:0] pr,
  input  logic            en,
  input  logic            start,
  input  logic [DW-1:0]   txdata,
  input  logic            rx_in,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   rxdata,
  output logic            sclk,
  output logic            dout
);

  localparam int            EW        = $clog2(2 * DW);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

  xfer_state_e     state_q, state_d;
  logic [PR_W-1:0] hp_q, hp_d, cnt_q, cnt_d;
  logic [EW-1:0]   edge_q, edge_d;
  logic            sclk_q, sclk_d, dout_q, dout_d;
  logic [DW-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [PR_W-1:0] pr_eff;
  logic            tick, last_edge, sample_edge;

  assign pr_eff    = (pr < PR_W'(2)) ? PR_W'(2) : pr;
  assign tick      = (state_q == ST_XFER) && en && (cnt_q == hp_q - PR_W'(1));
  assign last_edge = (edge_q == LAST_EDGE);
  // Leading edges are the odd ones; CPHA decides whether they sample or shift.
  assign sample_edge = ~edge_q[0] ^ cpha;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hp_q    <= PR_W'(PR_RESET);
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      dout_q  <= 1'b0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      dout_q  <= dout_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (start && en) state_d = ST_XFER;
    end else if (!en || (tick && last_edge)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    dout_d  = dout_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    if (state_q == ST_IDLE) begin
      if (start && en) begin
        hp_d    = pr_eff;
        cnt_d   = '0;
        edge_d  = '0;
        sclk_d  = cpol;
        rx_sr_d = '0;
        if (cpha) begin
          tx_sr_d = txdata;
        end else begin
          dout_d  = txdata[DW-1];
          tx_sr_d = {txdata[DW-2:0], 1'b0};
        end
      end
    end else if (tick) begin
      // Half-period is re-latched every edge so a new PR lands on a boundary.
      hp_d   = pr_eff;
      cnt_d  = '0;
      edge_d = edge_q + EW'(1);
      sclk_d = ~sclk_q;
      if (sample_edge) begin
        rx_sr_d = {rx_sr_q[DW-2:0], rx_in};
      end else begin
        dout_d  = tx_sr_q[DW-1];
        tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
      end
    end else begin
      cnt_d = cnt_q + PR_W'(1);
    end
  end

  always_comb begin
    busy   = (state_q == ST_XFER);
    done   = tick && last_edge;
    sclk   = busy ? sclk_q : cpol;
    dout   = dout_q;
    rxdata = rx_sr_d;
  end

endmodule

// File: rtl/ef_spi_apb.sv
// rtl/ef_spi_apb.sv - APB register front end, interrupts and SPI master top.
// EF_SPI_LOOPBACK_EN adds CTRL.LOOP (receive from internal dout instead of din).
module ef_spi_apb
  import ef_spi_pkg::*;
#(
  parameter int PR_W = 8,
  parameter int DW   = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        din,
  output logic        dout,
  output logic        csb,
  output logic        sclk,
  output logic        IRQ
);

  logic [1:0]      cfg_q, cfg_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [PR_W-1:0] pr_q, pr_d;
  logic [DW-1:0]   rxdata_q, rxdata_d;
  logic            rxv_q, rxv_d;
  logic [1:0]      ris_q, ris_d, im_q, im_d;
  logic            irq_q, irq_d;
  logic [15:0]     addr;
  logic            wr_en, rd_en, start, busy, done, rx_in;
  logic [DW-1:0]   rxdata_m;
  logic [1:0]      ris_set, ris_clr;
  logic            unused_bits;

`ifdef EF_SPI_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
  assign rx_in = ctrl_q[CTRL_LOOP] ? dout : din;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
  assign rx_in = din;
`endif

  assign addr        = PADDR[15:0];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign rd_en       = PSEL & PENABLE & ~PWRITE;
  assign start       = wr_en && (addr == ADDR_TXDATA) && ctrl_q[CTRL_EN] && !busy;
  assign PREADY      = 1'b1;
  assign csb         = ~ctrl_q[CTRL_SS];
  assign IRQ         = irq_q;
  assign unused_bits = ^{PADDR[31:16], PWDATA[31:PR_W]};

  ef_spi_master #(.PR_W(PR_W), .DW(DW)) u_master (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .cpol   (cfg_q[CFG_CPOL]),
    .cpha   (cfg_q[CFG_CPHA]),
    .pr     (pr_q),
    .en     (ctrl_q[CTRL_EN]),
    .start  (start),
    .txdata (PWDATA[DW-1:0]),
    .rx_in  (rx_in),
    .busy   (busy),
    .done   (done),
    .rxdata (rxdata_m),
    .sclk   (sclk),
    .dout   (dout)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cfg_q    <= '0;
      ctrl_q   <= '0;
      pr_q     <= PR_W'(PR_RESET);
      rxdata_q <= '0;
      rxv_q    <= 1'b0;
      ris_q    <= '0;
      im_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      ctrl_q   <= ctrl_d;
      pr_q     <= pr_d;
      rxdata_q <= rxdata_d;
      rxv_q    <= rxv_d;
      ris_q    <= ris_d;
      im_q     <= im_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    cfg_d  = cfg_q;
    ctrl_d = ctrl_q;
    pr_d   = pr_q;
    im_d   = im_q;
    if (wr_en) begin
      case (addr)
        ADDR_CFG:  cfg_d  = PWDATA[1:0];
        ADDR_CTRL: ctrl_d = PWDATA[2:0] & CTRL_MASK;
        ADDR_PR:   pr_d   = PWDATA[PR_W-1:0];
        ADDR_IM:   im_d   = PWDATA[1:0];
        default:   ;
      endcase
    end
    rxdata_d = done ? rxdata_m : rxdata_q;
    rxv_d    = rxv_q;
    if (rd_en && (addr == ADDR_RXDATA)) rxv_d = 1'b0;
    if (done) rxv_d = 1'b1;
    // Hardware set beats a same-cycle IC clear.
    ris_set           = '0;
    ris_set[RIS_DONE] = done;
    ris_set[RIS_RXOV] = done & rxv_q;
    ris_clr           = (wr_en && (addr == ADDR_IC)) ? PWDATA[1:0] : 2'b00;
    ris_d             = (ris_q & ~ris_clr) | ris_set;
    irq_d             = |(ris_q & im_q);
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (addr)
        ADDR_RXDATA: PRDATA = 32'(rxdata_q);
        ADDR_CFG:    PRDATA = 32'(cfg_q);
        ADDR_CTRL:   PRDATA = 32'(ctrl_q);
        ADDR_PR:     PRDATA = 32'(pr_q);
        ADDR_STATUS: PRDATA = 32'({rxv_q, busy});
        ADDR_IM:     PRDATA = 32'(im_q);
        ADDR_MIS:    PRDATA = 32'(ris_q & im_q);
        ADDR_RIS:    PRDATA = 32'(ris_q);
        default:     PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ef_spi_apb.sv
// tb/tb_ef_spi_apb.sv - randomized bench for ef_spi_apb with a behavioural
// SPI slave and register/interrupt model; EF_SPI_LOOPBACK_EN aware.
module tb_ef_spi_apb;

  localparam logic [15:0] A_RX   = 16'h0000;
  localparam logic [15:0] A_TX   = 16'h0004;
  localparam logic [15:0] A_CFG  = 16'h0008;
  localparam logic [15:0] A_CTRL = 16'h000C;
  localparam logic [15:0] A_PR   = 16'h0010;
  localparam logic [15:0] A_STAT = 16'h0014;
  localparam logic [15:0] A_IM   = 16'hFF00;
  localparam logic [15:0] A_MIS  = 16'hFF04;
  localparam logic [15:0] A_RIS  = 16'hFF08;
  localparam logic [15:0] A_IC   = 16'hFF0C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  wire  [31:0] prdata;
  wire         pready, dout, csb, sclk, irq;
  wire         din;
  logic        tie_loop = 1'b0, sl_bit = 1'b0;

  int          n_cmp = 0, n_bad = 0;

  logic [1:0]  m_ris = '0, m_im = '0;
  logic        m_rxv = 1'b0;
  logic [7:0]  m_rx = '0;

  int          n_edges = 0, n_samp = 0;
  logic [7:0]  mosi_cap = '0, sl_byte = '0;
  logic        csb_bad = 1'b0, mon_on = 1'b0, cur_cpol = 1'b0, cur_cpha = 1'b0, lead;

  assign din = tie_loop ? dout : sl_bit;

  always #5 clk = ~clk;

  ef_spi_apb dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PADDR   (paddr),
    .PWRITE  (pwrite),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .din     (din),
    .dout    (dout),
    .csb     (csb),
    .sclk    (sclk),
    .IRQ     (irq)
  );

  // Slave: captures MOSI and advances its own MISO bit on every sampling edge.
  always @(sclk) begin
    if (mon_on) begin
      n_edges++;
      if (csb !== 1'b0) csb_bad = 1'b1;
      lead = (sclk !== cur_cpol);
      if (lead != cur_cpha) begin
        mosi_cap = {mosi_cap[6:0], dout};
        n_samp++;
        if (n_samp < 8) sl_bit = sl_byte[7-n_samp];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    logic [15:0] junk;
    junk = 16'($urandom);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {junk, a}; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {16'h0, a};
    @(posedge clk); #1;
    penable = 1'b1;
    #1 d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic arm(input logic [7:0] sl);
    n_edges = 0; n_samp = 0; mosi_cap = '0; csb_bad = 1'b0;
    sl_byte = sl; sl_bit = sl[7]; mon_on = 1'b1;
  endtask

  task automatic set_cfg(input logic [1:0] c);
    apb_write(A_CFG, {30'h0, c});
    cur_cpol = c[0]; cur_cpha = c[1];
    check("sclk_idle_cfg", {31'h0, sclk}, {31'h0, c[0]});
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input logic [7:0] exp_rx,
                      input int hp, input bit poke);
    logic [31:0] r;
    arm(sl);
    apb_write(A_TX, {24'h0, tx});
    if (poke) begin
      apb_write(A_TX, 32'h55);
      repeat (16*hp-4) @(posedge clk);
    end else begin
      repeat (16*hp-1) @(posedge clk);
    end
    #1 check("edges_before_last", n_edges, 15);
    @(posedge clk); #1;
    check("edges_total", n_edges, 16);
    mon_on = 1'b0;
    check("mosi", {24'h0, mosi_cap}, {24'h0, tx});
    check("csb_low", {31'h0, csb_bad}, 32'h0);
    check("sclk_end", {31'h0, sclk}, {31'h0, cur_cpol});
    if (m_rxv) m_ris[1] = 1'b1;
    m_ris[0] = 1'b1;
    m_rxv = 1'b1;
    m_rx = exp_rx;
    apb_read(A_STAT, r); check("status", r, {30'h0, m_rxv, 1'b0});
    apb_read(A_RIS, r);  check("ris", r, {30'h0, m_ris});
  endtask

  task automatic read_rx();
    logic [31:0] r;
    apb_read(A_RX, r);
    check("rxdata", r, {24'h0, m_rx});
    m_rxv = 1'b0;
  endtask

  task automatic chk_irq();
    @(posedge clk); #1;
    check("irq", {31'h0, irq}, {31'h0, |(m_ris & m_im)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  tx, sl, exp_rx;
    logic [1:0]  b, c;
    int          hp, p, e;

    repeat (3) @(posedge clk); #1;
    check("rst_csb", {31'h0, csb}, 32'h1);
    check("rst_sclk", {31'h0, sclk}, 32'h0);
    check("rst_dout", {31'h0, dout}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    apb_read(A_RX, r);     check("rst_rx", r, 32'h0);
    apb_read(A_CFG, r);    check("rst_cfg", r, 32'h0);
    apb_read(A_CTRL, r);   check("rst_ctrl", r, 32'h0);
    apb_read(A_PR, r);     check("rst_pr", r, 32'h2);
    apb_read(A_STAT, r);   check("rst_status", r, 32'h0);
    apb_read(A_IM, r);     check("rst_im", r, 32'h0);
    apb_read(A_MIS, r);    check("rst_mis", r, 32'h0);
    apb_read(A_RIS, r);    check("rst_ris", r, 32'h0);
    apb_read(16'h0018, r); check("unmapped", r, 32'h0);

    // Wire loopback, mode 0, PR=4
    apb_write(A_CTRL, 32'h3);
    check("csb_ss", {31'h0, csb}, 32'h0);
    set_cfg(2'd0);
    apb_write(A_PR, 32'h4);
    tie_loop = 1'b1;
    xfer(8'hA5, 8'h00, 8'hA5, 4, 1'b0);
    read_rx();
    tie_loop = 1'b0;

    for (int m = 1; m < 4; m++) begin
      set_cfg(2'(m));
      xfer(8'h3C, 8'hC3, 8'hC3, 4, 1'b0);
      read_rx();
    end

    apb_write(A_IC, 32'h3); m_ris = '0;
    apb_write(A_IM, 32'h1); m_im = 2'b01;
    chk_irq();
    xfer(8'h81, 8'h5A, 8'h5A, 4, 1'b0);
    chk_irq();
    apb_write(A_IC, 32'h1); m_ris[0] = 1'b0;
    chk_irq();
    xfer(8'h18, 8'hE7, 8'hE7, 4, 1'b0);
    chk_irq();
    read_rx();
    apb_write(A_IC, 32'h3); m_ris = '0;

    set_cfg(2'd0);
    xfer(8'hF0, 8'h69, 8'h69, 4, 1'b1);
    read_rx();
    apb_write(A_IC, 32'h3); m_ris = '0;

    // Abort by clearing EN mid-transfer
    apb_write(A_PR, 32'h3);
    set_cfg(2'd1);
    arm(8'hAA);
    apb_write(A_TX, 32'h42);
    repeat (24) @(posedge clk);
    apb_write(A_CTRL, 32'h1);
    repeat (2) @(posedge clk); #1;
    check("abort_sclk", {31'h0, sclk}, {31'h0, cur_cpol});
    e = n_edges;
    apb_read(A_STAT, r); check("abort_status", r, 32'h0);
    apb_read(A_RIS, r);  check("abort_ris", r, 32'h0);
    apb_read(A_RX, r);   check("abort_rx", r, {24'h0, m_rx});
    repeat (40) @(posedge clk); #1;
    check("abort_quiet", n_edges, e);
    mon_on = 1'b0;
    apb_write(A_CTRL, 32'h3);

    for (int it = 0; it < 10; it++) begin
      c = 2'($urandom_range(0, 3));
      set_cfg(c);
      p = $urandom_range(0, 5);
      apb_write(A_PR, p);
      hp = (p < 2) ? 2 : p;
      tx = 8'($urandom);
      sl = 8'($urandom);
      xfer(tx, sl, sl, hp, 1'b0);
      if ($urandom_range(0, 1) == 1) read_rx();
      b = 2'($urandom_range(0, 3));
      apb_write(A_IC, {30'h0, b}); m_ris = m_ris & ~b;
      b = 2'($urandom_range(0, 3));
      apb_write(A_IM, {30'h0, b}); m_im = b;
      apb_read(A_MIS, r); check("mis", r, {30'h0, m_ris & m_im});
      chk_irq();
    end

    apb_write(A_CTRL, 32'h7);
    apb_read(A_CTRL, r);
`ifdef EF_SPI_LOOPBACK_EN
    check("ctrl_loop", r, 32'h7);
    exp_rx = 8'h96;
`else
    check("ctrl_loop", r, 32'h3);
    exp_rx = 8'h00;
`endif
    set_cfg(2'd0);
    apb_write(A_PR, 32'h2);
    xfer(8'h96, 8'h00, exp_rx, 2, 1'b0);
    read_rx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ef_spi_apb.md
Name: ef_spi_apb

Overview:
- APB-slave-controlled SPI master: 8-bit full-duplex transfers, MSB first.
- Supports all four SPI modes (CPOL/CPHA), a programmable SCK prescaler, software-controlled chip select and a maskable level interrupt.
- Sits on the peripheral APB bus; drives one external SPI slave through sclk/dout/csb and samples din.

Parameters:
- PR_W, 8, width of the prescaler register.
- DW, 8, transfer frame width in bits.

Ports:
- PCLK  input  1  system clock; all logic is on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PADDR  input  32  APB address; only bits [15:0] are decoded.
- PWRITE  input  1  APB write strobe.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB enable phase.
- PWDATA  input  32  APB write data.
- PRDATA  output  32  APB read data.
- PREADY  output  1  constant 1; no wait states.
- din  input  1  SPI MISO.
- dout  output  1  SPI MOSI.
- csb  output  1  SPI chip select, active low.
- sclk  output  1  SPI clock.
- IRQ  output  1  interrupt, active high.

Behaviour:
- APB write occurs when PSEL & PENABLE & PWRITE. PRDATA is combinational from PADDR while PSEL=1, else 0. Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0x0000 RXDATA (RO, [7:0]). Reading it clears STATUS.RXV.
  - 0x0004 TXDATA (WO). A write starts a transfer.
  - 0x0008 CFG: [0] CPOL, [1] CPHA.
  - 0x000C CTRL: [0] SS, [1] EN.
  - 0x0010 PR: prescaler [7:0]; reset value 2.
  - 0x0014 STATUS (RO): [0] BUSY, [1] RXV.
  - 0xFF00 IM: interrupt mask.
  - 0xFF04 MIS = RIS & IM.
  - 0xFF08 RIS: [0] DONE, [1] RXOV.
  - 0xFF0C IC (W1C): writing 1 clears the corresponding RIS bit.
- Reset values: all registers 0 except PR=2. Outputs: sclk=0, dout=0, csb=1, IRQ=0.
- csb = ~CTRL.SS, fully software-controlled and independent of BUSY.
- Starting a transfer: a TXDATA write with EN=1 and BUSY=0 loads the shift register and sets BUSY on the next edge. A TXDATA write while BUSY, or while EN=0, is ignored.
- SCK timing:
  - Half-period = max(PR,2) PCLK cycles.
  - A transfer is 16 half-periods (2×DW edges), so duration = 16·max(PR,2) cycles.
  - sclk idles at CPOL; the first edge occurs after the first half-period.
- CPHA=0: dout presents the MSB as soon as BUSY rises. din is sampled on leading (odd) edges; the next bit is shifted out on trailing edges.
- CPHA=1: a new bit is shifted out on leading edges; din is sampled on trailing edges.
- Completion, in the cycle of the final edge:
  - BUSY clears, sclk returns to CPOL, RXDATA is loaded and RIS.DONE is set.
  - If RXV was still 1, RIS.RXOV is set and RXDATA is overwritten.
  - RXV is set.
- PR written mid-transfer takes effect at the next half-period boundary.
- Clearing EN mid-transfer aborts the transfer: BUSY=0, sclk=CPOL, RXDATA unchanged, no DONE.
- IRQ = |MIS, registered one cycle after RIS/IM change.
- Simultaneous hardware set and IC clear of the same RIS bit: the set wins.
- Async reset mid-transfer returns everything to reset values immediately.

Optional Feature:
- Macro: EF_SPI_LOOPBACK_EN.
- When defined: CTRL[2] LOOP is implemented. With LOOP=1, the receive shifter samples internal dout instead of din; sclk, dout and csb still toggle.
- When undefined: CTRL[2] reads 0, writes are ignored, and din is always used.

Decomposition:
- Package ef_spi_pkg holds:
  - register offset constants;
  - bit-index constants (CPOL, CPHA, SS, EN, LOOP, BUSY, RXV, DONE, RXOV);
  - the reset value of PR.
- One natural sub-module, ef_spi_master: prescaler, edge counter and shift registers. It takes cpol, cpha, pr, en, start and txdata, and returns busy, done and rxdata. The top level holds the APB decode, registers and interrupt logic.

Test Plan:
- Reset -> csb=1, sclk=0, IRQ=0, PR reads 2, all other registers read 0.
- Write EN=1, SS=1, CFG=0, PR=4, TXDATA=0xA5, with din tied to dout -> 8 sclk pulses over 64 cycles, dout shows MSB first 1,0,1,0,0,1,0,1, RXDATA=0xA5, RIS.DONE=1, csb=0 throughout.
- Sweep CFG=1, 2, 3 with TXDATA=0x3C against a slave model returning 0xC3 -> sclk idles at CPOL, sample edge matches CPHA, RXDATA=0xC3 in every mode.
- Set IM=1 and complete a transfer -> IRQ=1. Write IC=1 -> IRQ=0. A second transfer without reading RXDATA -> RIS.RXOV=1.
- Write TXDATA=0x55 while BUSY -> ignored, and the in-flight byte completes unchanged. Clear EN at mid-transfer -> BUSY=0, sclk=CPOL, no DONE.
- With EF_SPI_LOOPBACK_EN defined and CTRL=0x7, din forced to 0, TXDATA=0x96 -> RXDATA=0x96.
